// File: rtl/addsub_sched_pkg.sv
// Shared types and constants for the time-shared saturating add/sub scheduler.
package addsub_sched_pkg;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DW-1:0] SAT_NEG = 16'h8000;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic          ovfl;
    logic          src;
  } rsp_t;

  // Subtraction is A + ~B + 1; overflow when effective operand signs agree but the result sign flips.
  function automatic rsp_t sat_addsub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic sub, input logic src);
    logic [DW-1:0] b_eff;
    logic [DW-1:0] raw;
    rsp_t          r;
    b_eff  = sub ? ~b : b;
    raw    = a + b_eff + DW'(sub);
    r.src  = src;
    r.ovfl = (a[DW-1] == b_eff[DW-1]) && (raw[DW-1] != a[DW-1]);
    r.sum  = r.ovfl ? (a[DW-1] ? SAT_NEG : SAT_POS) : raw;
    return r;
  endfunction

endpackage

// File: rtl/addsub_sched_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, last_grant remembers the previous winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant_c
);

  logic last_grant;

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (req == 2'b11) grant_c = last_grant ? 2'b01 : 2'b10;
      else              grant_c = req;
    end
  end

  // Reset to 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant <= 1'b1;
    else if (|grant_c) last_grant <= grant_c[1];
  end

endmodule

// File: rtl/addsub_sched.sv
// Time-shares one 16-bit saturating add/sub between two requesters with a one-deep result register.
module addsub_sched
  import addsub_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][DW-1:0]  req_a,
  input  logic [1:0][DW-1:0]  req_b,
  input  logic [1:0]          req_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_sum,
  output logic                rsp_ovfl,
  output logic                rsp_src,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    ovfl_cnt
);

  state_t     state, state_nxt;
  rsp_t       rsp_q, rsp_d;
  logic       slot_free;
  logic [1:0] grant;
  logic [1:0] accept_vec;
  logic       accept;
  logic       sel;

  assign slot_free = (state == EMPTY) | rsp_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (slot_free),
    .grant_c (grant)
  );

  assign req_ready  = grant;
  assign accept_vec = req_valid & grant;
  assign accept     = |accept_vec;
  assign sel        = accept_vec[1];
  assign rsp_d      = sat_addsub(req_a[sel], req_b[sel], req_sub[sel], sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Drain-and-refill in one cycle keeps FULL; a held result without rsp_ready stays FULL.
  always_comb begin
    state_nxt = EMPTY;
    if (accept)                             state_nxt = FULL;
    else if ((state == FULL) && !rsp_ready) state_nxt = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_q <= '0;
    else if (accept) rsp_q <= rsp_d;
  end

  // Clear has priority over the saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          ovfl_cnt <= '0;
    else if (cnt_clr)                                    ovfl_cnt <= '0;
    else if (accept && rsp_d.ovfl && (ovfl_cnt != '1))   ovfl_cnt <= ovfl_cnt + CNT_W'(1);
  end

  assign rsp_valid = (state == FULL);
  assign rsp_sum   = rsp_q.sum;
  assign rsp_ovfl  = rsp_q.ovfl;
  assign rsp_src   = rsp_q.src;

endmodule

// File: tb/tb_addsub_sched.sv
// Directed self-checking bench for addsub_sched with hand-computed expected values.
module tb_addsub_sched;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][15:0]  req_a;
  logic [1:0][15:0]  req_b;
  logic [1:0]        req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_sum;
  logic              rsp_ovfl;
  logic              rsp_src;
  logic              cnt_clr;
  logic [1:0]        ovfl_cnt;

  int checks;
  int failures;

  addsub_sched #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_ovfl  (rsp_ovfl),
    .rsp_src   (rsp_src),
    .cnt_clr   (cnt_clr),
    .ovfl_cnt  (ovfl_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [15:0] s,
                           input logic o, input logic src);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".sum"},   32'(rsp_sum),   32'(s));
    check({tag, ".ovfl"},  32'(rsp_ovfl),  32'(o));
    check({tag, ".src"},   32'(rsp_src),   32'(src));
  endtask

  initial begin
    #20000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_sub = 2'b00;
    rsp_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    check_rsp("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    check("reset.cnt", 32'(ovfl_cnt), 32'd0);
    step();
    rst_n = 1'b1;

    // Single request, latency 1
    req_valid = 2'b01; req_a[0] = 16'h1234; req_b[0] = 16'h0001; req_sub[0] = 1'b0; rsp_ready = 1'b1;
    #1 check("basic.ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    check_rsp("basic", 1'b1, 16'h1235, 1'b0, 1'b0);
    step();
    check("basic.drain", 32'(rsp_valid), 32'd0);

    // Positive then negative saturation from requester 1
    req_valid = 2'b10; req_a[1] = 16'h7FFF; req_b[1] = 16'h0001; req_sub[1] = 1'b0;
    step();
    check_rsp("satpos", 1'b1, 16'h7FFF, 1'b1, 1'b1);
    req_a[1] = 16'h8000; req_b[1] = 16'h0001; req_sub[1] = 1'b1;
    step();
    check_rsp("satneg", 1'b1, 16'h8000, 1'b1, 1'b1);
    check("sat.cnt", 32'(ovfl_cnt), 32'd2);
    req_valid = 2'b00;
    step();

    // Contention: alternate 0,1,... one result per cycle
    req_valid = 2'b11; req_sub = 2'b00;
    req_a[0] = 16'h0010; req_b[0] = 16'h0001;
    req_a[1] = 16'h0020; req_b[1] = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      #1 check("rr.ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check_rsp("rr", 1'b1, (i % 2 == 0) ? 16'h0011 : 16'h0022, 1'b0, 1'(i % 2));
    end
    req_valid = 2'b00;
    step();

    // Backpressure: hold FULL, then drain and accept together
    req_valid = 2'b01; req_a[0] = 16'h0100; req_b[0] = 16'h0001; req_sub[0] = 1'b1;
    step();
    rsp_ready = 1'b0; req_a[0] = 16'h0005; req_b[0] = 16'h0003; req_sub[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp.ready", 32'(req_ready), 32'h0);
      step();
      check_rsp("bp.hold", 1'b1, 16'h00FF, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 check("bp.release_ready", 32'(req_ready), 32'h1);
    step();
    check_rsp("bp.new", 1'b1, 16'h0008, 1'b0, 1'b0);
    req_valid = 2'b00;
    step();
    check("bp.drain", 32'(rsp_valid), 32'd0);

    // Counter clear, saturation at 3, and clear priority
    cnt_clr = 1'b1;
    step();
    check("cnt.clr", 32'(ovfl_cnt), 32'd0);
    cnt_clr = 1'b0;
    req_valid = 2'b01; req_a[0] = 16'h7FFF; req_b[0] = 16'h7FFF; req_sub[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("cnt.inc", 32'(ovfl_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      check_rsp("cnt.sat", 1'b1, 16'h7FFF, 1'b1, 1'b0);
    end
    cnt_clr = 1'b1; req_a[0] = 16'h8000; req_b[0] = 16'h8000;
    step();
    check("cnt.clrprio", 32'(ovfl_cnt), 32'd0);
    check_rsp("cnt.negsat", 1'b1, 16'h8000, 1'b1, 1'b0);
    cnt_clr = 1'b0; req_a[0] = 16'h0005; req_b[0] = 16'h0007; req_sub[0] = 1'b1;
    step();
    check_rsp("subneg", 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check("subneg.cnt", 32'(ovfl_cnt), 32'd0);
    req_valid = 2'b00;
    step();

    // Async reset while FULL, then contended grant goes to 0
    req_valid = 2'b01; req_a[0] = 16'h0001; req_b[0] = 16'h0001; req_sub[0] = 1'b0;
    step();
    req_valid = 2'b00; rsp_ready = 1'b0;
    check_rsp("pre_rst", 1'b1, 16'h0002, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_rsp("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    req_valid = 2'b11; rsp_ready = 1'b1;
    req_a[0] = 16'h0003; req_b[0] = 16'h0004;
    req_a[1] = 16'h0100; req_b[1] = 16'h0000; req_sub = 2'b00;
    #1 check("post_rst.ready", 32'(req_ready), 32'h1);
    step();
    check_rsp("post_rst.first", 1'b1, 16'h0007, 1'b0, 1'b0);
    step();
    check_rsp("post_rst.second", 1'b1, 16'h0100, 1'b0, 1'b1);
    req_valid = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_sched.md
ADDSUB_SCHED -- requirements
Module: addsub_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the overflow event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester operation valid; index 0 and 1.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 SHALL have port req_a  input  2x16  per-requester signed operand A.
REQ-007 SHALL have port req_b  input  2x16  per-requester signed operand B.
REQ-008 SHALL have port req_sub  input  2  per-requester op select; 1 = A-B, 0 = A+B.
REQ-009 SHALL have port rsp_valid  output  1  result register holds valid data.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result this cycle.
REQ-011 SHALL have port rsp_sum  output  16  saturated signed result.
REQ-012 SHALL have port rsp_ovfl  output  1  result was saturated.
REQ-013 SHALL have port rsp_src  output  1  index of requester that issued the result.
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of ovfl_cnt.
REQ-015 SHALL have port ovfl_cnt  output  CNT_W  count of saturated results issued.

Function
REQ-016 SHALL time-share one 16-bit saturating add/sub datapath between the two requesters.
REQ-017 SHALL implement FSM states EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-018 SHALL define slot_free = (state==EMPTY) | rsp_ready; no grant when slot_free=0.
REQ-019 SHALL grant the sole valid requester when exactly one req_valid is set and slot_free=1.
REQ-020 SHALL, when both valid and slot_free=1, grant the requester not equal to last_grant; last_grant updates on every grant.
REQ-021 SHALL drive req_ready combinationally equal to the grant vector; accept = req_valid[i] & req_ready[i].
REQ-022 SHALL compute A+B or A+~B+1 per req_sub; overflow = operand signs (B inverted for sub) equal and result sign differs.
REQ-023 SHALL saturate: positive overflow -> 16'h7FFF, negative overflow -> 16'h8000, rsp_ovfl=1; else raw sum, rsp_ovfl=0.
REQ-024 SHALL register rsp_sum/rsp_ovfl/rsp_src on accept; rsp_valid asserts the following cycle (latency 1).
REQ-025 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL with new data on rsp_ready with accept.
REQ-026 SHALL hold rsp_* stable and req_ready=0 while FULL and rsp_ready=0.
REQ-027 SHALL sustain one result per cycle when rsp_ready is held 1 and requests are continuous.
REQ-028 SHALL increment ovfl_cnt on each accept whose computed overflow is 1, saturating at 2^CNT_W-1.
REQ-029 SHALL give cnt_clr priority: clear and increment in the same cycle yields 0.
REQ-030 SHALL ignore req_a/req_b/req_sub of non-granted requesters.

Reset
REQ-031 SHALL on rst_n=0 immediately force state=EMPTY, rsp_valid=0, rsp_sum=0, rsp_ovfl=0, rsp_src=0, ovfl_cnt=0, last_grant=1.
REQ-032 SHALL discard any held result on reset mid-operation; requester 0 wins the first contended grant after release.

Structure
REQ-033 SHALL place the state enum, DW=16, SAT_POS=16'h7FFF, SAT_NEG=16'h8000 in package addsub_sched_pkg.
REQ-034 SHALL implement arbitration in sub-module rr_arb2 (2-way round-robin, last_grant register inside).
REQ-035 SHALL keep the saturating add/sub combinational inside addsub_sched; no other sub-modules.

Verification
REQ-036 SHALL cover: req0 0x1234+0x0001, rsp_ready=1 -> next cycle rsp_valid=1, sum 0x1235, ovfl 0, src 0.
REQ-037 SHALL cover: 0x7FFF+0x0001 then 0x8000-0x0001 -> sums 0x7FFF, 0x8000, ovfl 1 each, ovfl_cnt=2.
REQ-038 SHALL cover: both valid for 6 cycles, rsp_ready=1 -> srcs 0,1,0,1,0,1, one result per cycle.
REQ-039 SHALL cover: FULL, rsp_ready=0 for 3 cycles -> req_ready=00, rsp stable; rsp_ready=1 -> drain and new accept same cycle.
REQ-040 SHALL cover: CNT_W=2, 4 overflows -> ovfl_cnt=3; cnt_clr with overflow accept same cycle -> 0.
REQ-041 SHALL cover: rst_n low mid-FULL -> rsp_valid=0 without clock edge; after release both valid -> src 0 first.
